// File: rtl/risc_div_pkg.sv
// Shared definitions for the parametrised divider: legal radix choices,
// counter sizing and the Euclidean result fix-up used by the datapath.
package risc_div_pkg;

    // Widest operand the result-fix helpers can handle.
    localparam int MAXW = 128;

    // Bit b set means b quotient bits per cycle is a legal choice (1, 2, 4).
    localparam logic [7:0] ALLOWED_BPC = 8'b0001_0110;

    localparam logic [MAXW-1:0] ONE = {{(MAXW-1){1'b0}}, 1'b1};

    // Operation phase decoded from the step counter.
    typedef enum logic [1:0] {
        PH_LOAD   = 2'd0,
        PH_ITER   = 2'd1,
        PH_RESULT = 2'd2
    } phase_t;

    function automatic logic bpc_allowed(input int b);
        return (b >= 0 && b < 8) ? ALLOWED_BPC[b] : 1'b0;
    endfunction

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic [MAXW-1:0] width_mask(input int w);
        return (w >= MAXW) ? {MAXW{1'b1}} : ((ONE << w) - ONE);
    endfunction

    // Euclidean quotient from the unsigned quotient qa / remainder ra of
    // |x| / |y|; a zero divisor forces an all-ones quotient.
    function automatic logic [MAXW-1:0] fix_quot(
        input logic [MAXW-1:0] qa,
        input logic [MAXW-1:0] ra,
        input logic            sx,
        input logic            sy,
        input logic            zf,
        input int              w
    );
        logic [MAXW-1:0] m;
        logic [MAXW-1:0] q0;
        logic [MAXW-1:0] q;
        m  = width_mask(w);
        q0 = sx ? ((ra == '0) ? -qa : -(qa + ONE)) : qa;
        q0 = q0 & m;
        q  = sy ? -q0 : q0;
        q  = q & m;
        if (zf) q = m;
        return q;
    endfunction

    // Euclidean remainder: always in 0 .. |y|-1; equals x when y is zero.
    function automatic logic [MAXW-1:0] fix_rem(
        input logic [MAXW-1:0] ra,
        input logic [MAXW-1:0] ay,
        input logic            sx,
        input int              w
    );
        logic [MAXW-1:0] r;
        r = (sx && ra != '0) ? (ay - ra) : ra;
        return r & width_mask(w);
    endfunction

endpackage

// File: rtl/risc_div_step.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module risc_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rin,
    input  logic [WIDTH-1:0] d,
    input  logic             bit_in,
    output logic [WIDTH:0]   rout,
    output logic             q
);

    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] dx;

    // Trial subtraction; the remainder stays below the divisor so WIDTH+1 bits suffice.
    always_comb begin
        t    = {rin, bit_in};
        dx   = {2'b00, d};
        q    = (t >= dx);
        rout = q ? (WIDTH+1)'(t - dx) : (WIDTH+1)'(t);
    end

endmodule

// File: rtl/risc_divider_p.sv
// Multi-cycle Euclidean integer divider with the core's run/stall/ce
// handshake. Step counter S: 0 = load, 1..ITER = iterate, ITER+1 = result.
module risc_divider_p
    import risc_div_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             run,
    input  logic             u,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             stall,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int SW   = clog2(ITER + 2);
    localparam logic [SW-1:0] S_LAST = SW'(ITER + 1);

    generate
        if (!bpc_allowed(BITS_PER_CYCLE) || (WIDTH % BITS_PER_CYCLE) != 0
            || WIDTH < 4 || WIDTH >= MAXW) begin : g_bad_params
            $error("risc_divider_p: illegal WIDTH/BITS_PER_CYCLE combination");
        end
    endgenerate

    logic [SW-1:0]    s_reg;
    logic [SW-1:0]    s_next;
    phase_t           phase;
    logic             load_en;
    logic             iter_en;

    logic [WIDTH-1:0] dq_reg;    // dividend shifting out at the top, quotient in at the bottom
    logic [WIDTH:0]   rem_reg;   // partial remainder
    logic [WIDTH-1:0] ay_reg;    // |y|
    logic             sx_reg;
    logic             sy_reg;
    logic             zf_reg;

    logic             x_neg;
    logic             y_neg;
    logic [WIDTH-1:0] ax;
    logic [WIDTH-1:0] ay;

    logic [WIDTH:0]          r_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] q_bits;
    logic [WIDTH-1:0]        dq_next;

    // Step counter register; freezes while ce is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg <= '0;
        end else if (ce) begin
            s_reg <= s_next;
        end
    end

    // Next step: advance while run is held, wrap after the result cycle.
    always_comb begin
        s_next = '0;
        if (run) begin
            s_next = (s_reg == S_LAST) ? '0 : s_reg + SW'(1);
        end
    end

    // Phase decode, stall and datapath enables.
    always_comb begin
        phase = PH_ITER;
        if (s_reg == '0)         phase = PH_LOAD;
        else if (s_reg == S_LAST) phase = PH_RESULT;
        stall   = run & (phase != PH_RESULT);
        load_en = ce & run & (phase == PH_LOAD);
        iter_en = ce & run & (phase == PH_ITER);
    end

    // Operand magnitudes; negation only for signed operands with the sign bit set.
    always_comb begin
        x_neg = u & x[WIDTH-1];
        y_neg = u & y[WIDTH-1];
        ax    = x_neg ? -x : x;
        ay    = y_neg ? -y : y;
    end

    assign r_chain[0] = rem_reg;

    // BITS_PER_CYCLE restoring steps per cycle, most significant dividend bit first.
    generate
        for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            risc_div_step #(.WIDTH(WIDTH)) u_step (
                .rin    (r_chain[gi]),
                .d      (ay_reg),
                .bit_in (dq_reg[WIDTH-1-gi]),
                .rout   (r_chain[gi+1]),
                .q      (q_bits[BITS_PER_CYCLE-1-gi])
            );
        end
    endgenerate

    assign dq_next = (dq_reg << BITS_PER_CYCLE) | WIDTH'(q_bits);

    // Working registers: capture operands at load, iterate afterwards, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_reg  <= '0;
            rem_reg <= '0;
            ay_reg  <= '0;
            sx_reg  <= 1'b0;
            sy_reg  <= 1'b0;
            zf_reg  <= 1'b0;
        end else if (load_en) begin
            dq_reg  <= ax;
            rem_reg <= '0;
            ay_reg  <= ay;
            sx_reg  <= x_neg;
            sy_reg  <= y_neg;
            zf_reg  <= (y == '0);
        end else if (iter_en) begin
            dq_reg  <= dq_next;
            rem_reg <= r_chain[BITS_PER_CYCLE];
        end
    end

    // Euclidean fix-up of the unsigned quotient/remainder held in the working registers.
    always_comb begin
        quot = WIDTH'(fix_quot(MAXW'(dq_reg), MAXW'(rem_reg), sx_reg, sy_reg, zf_reg, WIDTH));
        rem  = WIDTH'(fix_rem(MAXW'(rem_reg), MAXW'(ay_reg), sx_reg, WIDTH));
        dz   = zf_reg;
    end

endmodule
